// File: rtl/cfg_tgate_mux.sv
// cfg_tgate_mux: NUM_IN-way, DATA_W-bit routing mux whose one-hot select is
// shifted in on the configuration chain, checked for legality and committed
// to an active register. Optional feature macro: CFG_MUX_READBACK_EN (lets the
// active select be reloaded into the chain and shifted out on ccff_tail).
module cfg_tgate_mux #(
   parameter int unsigned NUM_IN  = 4,
   parameter int unsigned DATA_W  = 1,
   parameter bit          INV_OUT = 1'b0
) (
   input  logic                     prog_clk,
   input  logic                     prog_rstn,
   input  logic                     ccff_en,
   input  logic                     ccff_head,
   input  logic                     cfg_commit,
   input  logic                     cfg_readback,
   input  logic [NUM_IN*DATA_W-1:0] in,
   output logic                     ccff_tail,
   output logic [NUM_IN-1:0]        mem_out,
   output logic [NUM_IN-1:0]        mem_outb,
   output logic [DATA_W-1:0]        out,
   output logic                     cfg_valid,
   output logic                     cfg_err
);

   localparam int unsigned CNT_W = $clog2(NUM_IN + 1);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(NUM_IN);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_LOADING,
      ST_LOADED
   } state_e;

   state_e              state_q, state_d;
   logic [NUM_IN-1:0]   sr_q, sr_d;
   logic [NUM_IN-1:0]   act_q, act_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                valid_q, valid_d;
   logic                err_q, err_d;
   logic                sr_legal;
   logic                readback_go;
   logic [DATA_W-1:0]   mux_raw;

`ifndef CFG_MUX_READBACK_EN
   logic unused_readback;
   assign unused_readback = cfg_readback;
`endif

   // Legal select: zero or exactly one bit set.
   always_comb begin
      sr_legal = ((sr_q & (sr_q - NUM_IN'(1))) == '0);
   end

   // Next-state for chain, counter, FSM and committed select.
   always_comb begin
      state_d     = state_q;
      sr_d        = sr_q;
      act_d       = act_q;
      cnt_d       = cnt_q;
      valid_d     = valid_q;
      err_d       = err_q;
      readback_go = 1'b0;
`ifdef CFG_MUX_READBACK_EN
      readback_go = cfg_readback && (state_q == ST_IDLE);
`endif
      if (readback_go) begin
         // Readback wins over shift and commit in the same cycle.
         sr_d    = act_q;
         cnt_d   = CNT_FULL;
         state_d = ST_LOADED;
      end else begin
         // Commit is resolved first against the pre-shift sr; a simultaneous
         // shift then starts a fresh load from whatever state commit left.
         if (cfg_commit) begin
            if (state_q == ST_LOADED) begin
               if (sr_legal) begin
                  act_d   = sr_q;
                  valid_d = 1'b1;
                  err_d   = 1'b0;
               end else begin
                  act_d   = '0;
                  valid_d = 1'b0;
                  err_d   = 1'b1;
               end
               state_d = ST_IDLE;
               cnt_d   = '0;
            end else begin
               err_d = 1'b1;
            end
         end
         if (ccff_en) begin
            sr_d = {sr_q[NUM_IN-2:0], ccff_head};
            if (state_d == ST_IDLE) begin
               state_d = ST_LOADING;
               cnt_d   = CNT_ONE;
            end else if (cnt_d != CNT_FULL) begin
               cnt_d = cnt_d + CNT_ONE;
               if (cnt_d == CNT_FULL) begin
                  state_d = ST_LOADED;
               end
            end
         end
      end
   end

   // Configuration registers with synchronous active-low reset.
   always_ff @(posedge prog_clk) begin
      if (!prog_rstn) begin
         state_q <= ST_IDLE;
         sr_q    <= '0;
         act_q   <= '0;
         cnt_q   <= '0;
         valid_q <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         sr_q    <= sr_d;
         act_q   <= act_d;
         cnt_q   <= cnt_d;
         valid_q <= valid_d;
         err_q   <= err_d;
      end
   end

   // AND-OR select; an all-zero act yields zero instead of floating.
   always_comb begin
      mux_raw = '0;
      for (int unsigned i = 0; i < NUM_IN; i++) begin
         mux_raw = mux_raw | (in[i*DATA_W +: DATA_W] & {DATA_W{act_q[i]}});
      end
   end

   // Output stage; the if/else-if chain sends X or Z on a bit to 0.
   always_comb begin
      out = '0;
      for (int unsigned j = 0; j < DATA_W; j++) begin
         if (mux_raw[j]) begin
            out[j] = ~INV_OUT;
         end else if (!mux_raw[j]) begin
            out[j] = INV_OUT;
         end else begin
            out[j] = 1'b0;
         end
      end
   end

   assign ccff_tail = sr_q[NUM_IN-1];
   assign mem_out   = act_q;
   assign mem_outb  = ~act_q;
   assign cfg_valid = valid_q;
   assign cfg_err   = err_q;

endmodule

// File: tb/tb_cfg_tgate_mux.sv
// Directed bench for cfg_tgate_mux (NUM_IN=4, DATA_W=4), with one buffered and
// one inverting instance sharing the same stimulus.
module tb_cfg_tgate_mux;

   localparam int unsigned NI = 4;
   localparam int unsigned DW = 4;

   logic              prog_clk = 1'b0;
   logic              prog_rstn = 1'b0;
   logic              ccff_en = 1'b0;
   logic              ccff_head = 1'b0;
   logic              cfg_commit = 1'b0;
   logic              cfg_readback = 1'b0;
   logic [NI*DW-1:0]  in_bus = 16'hA53C;

   logic              tail_n, tail_i;
   logic [NI-1:0]     mem_n, mem_i, memb_n, memb_i;
   logic [DW-1:0]     out_n, out_i;
   logic              valid_n, valid_i, err_n, err_i;

   cfg_tgate_mux #(.NUM_IN(NI), .DATA_W(DW), .INV_OUT(1'b0)) dut_n (
      .prog_clk(prog_clk), .prog_rstn(prog_rstn), .ccff_en(ccff_en),
      .ccff_head(ccff_head), .cfg_commit(cfg_commit), .cfg_readback(cfg_readback),
      .in(in_bus), .ccff_tail(tail_n), .mem_out(mem_n), .mem_outb(memb_n),
      .out(out_n), .cfg_valid(valid_n), .cfg_err(err_n)
   );

   cfg_tgate_mux #(.NUM_IN(NI), .DATA_W(DW), .INV_OUT(1'b1)) dut_i (
      .prog_clk(prog_clk), .prog_rstn(prog_rstn), .ccff_en(ccff_en),
      .ccff_head(ccff_head), .cfg_commit(cfg_commit), .cfg_readback(cfg_readback),
      .in(in_bus), .ccff_tail(tail_i), .mem_out(mem_i), .mem_outb(memb_i),
      .out(out_i), .cfg_valid(valid_i), .cfg_err(err_i)
   );

   always #5 prog_clk = ~prog_clk;

   typedef struct {
      string      tag;
      logic [3:0] mem;
      logic       valid;
      logic       err;
   } exp_t;

   exp_t sb[$];
   logic tail_q[$];
   int   n_assert = 0;
   int   n_fail = 0;

   // Expected mux value for a one-hot/zero select over the 4x4 input bus.
   function automatic logic [3:0] sel_val(input logic [3:0] m, input logic [15:0] b);
      case (m)
         4'b0001: return b[3:0];
         4'b0010: return b[7:4];
         4'b0100: return b[11:8];
         4'b1000: return b[15:12];
         default: return 4'h0;
      endcase
   endfunction

   task automatic chk4(input string tag, input logic [3:0] obs, input logic [3:0] exp_v);
      n_assert++;
      assert (obs === exp_v) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
      end
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp_v);
      n_assert++;
      assert (obs === exp_v) else begin
         n_fail++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp_v);
      end
   endtask

   task automatic tick();
      @(posedge prog_clk);
      #1;
   endtask

   task automatic expect_cfg(input string tag, input logic [3:0] m, input logic v, input logic e);
      exp_t x;
      x.tag = tag; x.mem = m; x.valid = v; x.err = e;
      sb.push_back(x);
   endtask

   task automatic check_cfg();
      exp_t x;
      logic [3:0] sv;
      n_assert++;
      assert (sb.size() != 0) else begin
         n_fail++;
         $error("FAIL scoreboard_empty: observed size %0d expected >0", sb.size());
      end
      if (sb.size() != 0) begin
         x  = sb.pop_front();
         sv = sel_val(x.mem, in_bus);
         chk4({x.tag, ".mem_out"},  mem_n,  x.mem);
         chk4({x.tag, ".mem_outb"}, memb_n, ~x.mem);
         chk1({x.tag, ".valid"},    valid_n, x.valid);
         chk1({x.tag, ".err"},      err_n,   x.err);
         chk4({x.tag, ".out"},      out_n,  sv);
         chk4({x.tag, ".mem_inv"},  mem_i,  x.mem);
         chk4({x.tag, ".out_inv"},  out_i,  ~sv);
      end
   endtask

   task automatic shift_bit(input logic b);
      ccff_en = 1'b1; ccff_head = b;
      tick();
      ccff_en = 1'b0; ccff_head = 1'b0;
   endtask

   task automatic shift4(input logic b0, input logic b1, input logic b2, input logic b3);
      shift_bit(b0); shift_bit(b1); shift_bit(b2); shift_bit(b3);
   endtask

   task automatic commit_chk(input string tag, input logic [3:0] m, input logic v, input logic e);
      expect_cfg(tag, m, v, e);
      cfg_commit = 1'b1;
      tick();
      cfg_commit = 1'b0;
      check_cfg();
   endtask

   task automatic shift_tail(input string tag, input logic b);
      logic e;
      tail_q.push_back(b);
      shift_bit(b);
      e = tail_q.pop_front();
      chk1(tag, tail_n, e);
   endtask

   task automatic reset_chk(input string tag, input int unsigned cycles);
      expect_cfg(tag, 4'b0000, 1'b0, 1'b0);
      prog_rstn = 1'b0;
      for (int unsigned k = 0; k < cycles; k++) tick();
      check_cfg();
      chk1({tag, ".tail"}, tail_n, 1'b0);
      prog_rstn = 1'b1;
      tail_q.delete();
      tail_q.push_back(1'b0); tail_q.push_back(1'b0); tail_q.push_back(1'b0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic tb_bit;
      reset_chk("reset", 2);

      shift4(1'b1, 1'b0, 1'b0, 1'b0);
      commit_chk("legal_1000", 4'b1000, 1'b1, 1'b0);

      shift4(1'b1, 1'b1, 1'b0, 1'b0);
      commit_chk("illegal_1100", 4'b0000, 1'b0, 1'b1);

      shift4(1'b0, 1'b1, 1'b0, 1'b0);
      commit_chk("legal_0100", 4'b0100, 1'b1, 1'b0);

      shift_bit(1'b0); shift_bit(1'b0);
      commit_chk("partial_2", 4'b0100, 1'b1, 1'b1);
      shift_bit(1'b1); shift_bit(1'b0);
      commit_chk("complete_0010", 4'b0010, 1'b1, 1'b0);

      // Commit with a concurrent shift: pre-shift sr committed, new load at cnt=1.
      shift4(1'b0, 1'b0, 1'b0, 1'b1);
      ccff_en = 1'b1; ccff_head = 1'b1;
      commit_chk("commit_shift", 4'b0001, 1'b1, 1'b0);
      ccff_en = 1'b0; ccff_head = 1'b0;
      shift_bit(1'b0); shift_bit(1'b0); shift_bit(1'b0);
      commit_chk("after_cnt1", 4'b1000, 1'b1, 1'b0);
      commit_chk("idle_commit", 4'b1000, 1'b1, 1'b1);

      for (int k = 0; k < 3; k++) begin
         in_bus = 16'($urandom);
         expect_cfg("datapath_rand", 4'b1000, 1'b1, 1'b1);
         #1;
         check_cfg();
      end
      in_bus = 16'hA53C;

      reset_chk("reset2", 1);
      for (int k = 0; k < 8; k++) begin
         tb_bit = (8'b0100_1011 >> k) & 8'h01;
         shift_tail("tail_delay", tb_bit);
      end
      commit_chk("after_8_shifts", 4'b0010, 1'b1, 1'b0);

      shift_bit(1'b1); shift_bit(1'b0);
      reset_chk("reset_midload", 1);
      shift_bit(1'b0); shift_bit(1'b1);
      commit_chk("post_reset_partial", 4'b0000, 1'b0, 1'b1);

      prog_rstn = 1'b0; tick(); prog_rstn = 1'b1;
      shift4(1'b0, 1'b1, 1'b0, 1'b0);
      commit_chk("pre_readback", 4'b0100, 1'b1, 1'b0);
`ifdef CFG_MUX_READBACK_EN
      cfg_readback = 1'b1; tick(); cfg_readback = 1'b0;
      tail_q.delete();
      tail_q.push_back(1'b0); tail_q.push_back(1'b1);
      tail_q.push_back(1'b0); tail_q.push_back(1'b0);
      chk1("readback_tail0", tail_n, tail_q.pop_front());
      for (int k = 0; k < 3; k++) begin
         shift_bit(1'b0);
         chk1("readback_tail", tail_n, tail_q.pop_front());
      end
      shift_bit(1'b0);
      commit_chk("readback_recommit", 4'b0000, 1'b1, 1'b0);
`else
      cfg_readback = 1'b1; tick(); cfg_readback = 1'b0;
      commit_chk("readback_ignored", 4'b0100, 1'b1, 1'b1);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/cfg_tgate_mux.md
# cfg_tgate_mux

Parametrised, configuration-chain-programmed routing multiplexer for the FPGA fabric. It generalises the single-bit transmission-gate cell into an NUM_IN-way, DATA_W-bit mux with optional output inversion. Its one-hot select is shifted in serially on the programming chain, checked for legality and committed to a shadow register. It sits in switch/connection blocks between the ccff chain and the routing tracks.

## Interface
- NUM_IN, default 4: mux inputs; legal range 2..32.
- DATA_W, default 1: bits per input.
- INV_OUT, default 0: 0 selects a non-inverting output stage (buffer); 1 selects an inverting output stage (tapered inverter).
- prog_clk  input  1  programming clock; the only clock.
- prog_rstn  input  1  reset; synchronous, active-low.
- ccff_en  input  1  shift enable for the configuration chain.
- ccff_head  input  1  serial configuration data in.
- cfg_commit  input  1  single-cycle pulse; requests a commit of the shift register to the active register.
- cfg_readback  input  1  used only with CFG_MUX_READBACK_EN (see Configuration); ignored otherwise.
- in  input  NUM_IN*DATA_W  routing inputs; input i occupies bits [i*DATA_W +: DATA_W].
- ccff_tail  output  1  serial configuration data out, equal to sr[NUM_IN-1].
- mem_out  output  NUM_IN  active select, one-hot or zero.
- mem_outb  output  NUM_IN  bitwise complement of mem_out.
- out  output  DATA_W  mux output.
- cfg_valid  output  1  last commit was legal.
- cfg_err  output  1  sticky error flag.

## Operation
- Registers:
  - sr[NUM_IN-1:0]: shift register.
  - act[NUM_IN-1:0]: active select.
  - cnt: shift counter, clog2(NUM_IN+1) bits, saturating at NUM_IN.
  - state: IDLE, LOADING or LOADED.
- Shift: when ccff_en=1, sr <= {sr[NUM_IN-2:0], ccff_head}.
- State machine and counter:
  - IDLE -> LOADING on the first shift; cnt becomes 1.
  - LOADING -> LOADED when cnt reaches NUM_IN.
  - Further shifts in LOADED keep cnt saturated and update sr.
- Commit in LOADED, sr legal (exactly one bit set, or all zero):
  - act <= sr.
  - cfg_valid <= 1.
  - cfg_err <= 0.
  - state -> IDLE, cnt <= 0.
- Commit in LOADED, sr illegal (two or more bits set):
  - act <= 0, cfg_valid <= 0, cfg_err <= 1.
  - state -> IDLE, cnt <= 0.
- Commit in IDLE or LOADING (partial load):
  - act is unchanged.
  - cfg_err <= 1; cfg_valid is unchanged.
  - state and cnt are unchanged.
- Commit and ccff_en asserted in the same cycle:
  - The commit evaluates sr as it was before the shift.
  - The shift still occurs.
  - Resulting state is LOADING with cnt=1.
- Datapath:
  - mux = in[i] where act[i]=1; mux = 0 when act is all zero. The output never floats; this replaces the high-Z of the single-bit gate.
  - out = INV_OUT ? ~mux : mux.
  - Any X or Z on the selected input maps to 0 at the output, for determinism in simulation.

## Timing
- Configuration path: all registers update on the rising edge of prog_clk.
- ccff_tail has one cycle per stage: a bit entering at ccff_head appears at ccff_tail NUM_IN cycles later.
- Commit latency: mem_out, cfg_valid and cfg_err update on the edge that samples cfg_commit=1.
- Datapath is combinational (zero cycles) from in and act to out.
- Reset has priority over everything. With prog_rstn=0 at an edge:
  - sr=0, act=0, cnt=0, state=IDLE.
  - cfg_valid=0, cfg_err=0, ccff_tail=0.
  - mem_out=0, mem_outb all ones.
  - out = 0 when INV_OUT=0; out = all ones when INV_OUT=1.
- Reset mid-load discards the partial load; the next shift begins a new load from IDLE.

## Configuration
- Macro: CFG_MUX_READBACK_EN.
- Defined: cfg_readback=1 in IDLE loads sr <= act, sets cnt=NUM_IN and moves to LOADED, so the active select can be shifted out on ccff_tail.
  - Readback outside IDLE is ignored.
  - Readback has priority over ccff_en in the same cycle; cfg_commit in the same cycle is ignored.
- Not defined: cfg_readback is unused, and no readback logic is synthesised.

## Test plan
- Reset, NUM_IN=4, INV_OUT=0: hold prog_rstn=0 for 2 cycles -> mem_out=4'b0000, mem_outb=4'b1111, out=0, cfg_valid=0, cfg_err=0.
- Shift 1,0,0,0 (first bit in is 1), commit, in={4'hA,4'h5,4'h3,4'hC} with DATA_W=4 -> mem_out=4'b1000, out=4'hA, cfg_valid=1; with INV_OUT=1, out=4'h5.
- Shift 1,1,0,0, commit -> act=0, out=0, cfg_err=1, cfg_valid=0; then a legal load plus commit clears cfg_err.
- Shift 2 bits, commit -> cfg_err=1, mem_out unchanged; then 2 more shifts and a commit -> LOADED path taken and the legal value applied.
- Commit and ccff_en in the same cycle in LOADED -> the pre-shift sr is committed, state=LOADING, cnt=1. Separately, shift 8 bits with NUM_IN=4 -> ccff_tail reproduces the first 4 bits, delayed by 4 cycles.
- CFG_MUX_READBACK_EN defined: commit 4'b0100, pulse cfg_readback, then 4 shifts -> ccff_tail emits 0,1,0,0 (MSB first).
